// File: rtl/trig_pkg.sv
// Shared widths, enums and tag bundle for the trig lookup path.
// Used by angle_sweep_gen, sweep_tag_pipe and the trigonometric stage.
package trig_pkg;

  localparam int DEG_W    = 12;
  localparam int VAL_W    = 10;
  localparam int CNT_W    = 13;
  localparam int DEG_FULL = 3600;

  localparam logic [DEG_W-1:0] DEG_FULL_D = DEG_W'(DEG_FULL);
  localparam logic [DEG_W-1:0] DEG_MAX_D  = DEG_W'(DEG_FULL - 1);
  localparam logic [DEG_W:0]   DEG_FULL_X = (DEG_W+1)'(DEG_FULL);

  typedef enum logic [1:0] {
    MODE_SIN = 2'b00,
    MODE_COS = 2'b01,
    MODE_ALT = 2'b10,
    MODE_RSV = 2'b11
  } sweep_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } sweep_state_e;

  typedef struct packed {
    logic             vld;
    logic [DEG_W-1:0] deg;
    logic             cos;
  } sweep_tag_t;

  function automatic logic [DEG_W-1:0] deg_add(
    input logic [DEG_W-1:0] a,
    input logic [DEG_W-1:0] b
  );
    logic [DEG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEG_FULL_X) s = s - DEG_FULL_X;
    return s[DEG_W-1:0];
  endfunction

endpackage

// File: rtl/sweep_tag_pipe.sv
// LAT-stage shift register carrying {valid, degree, iscos} alongside
// the lookup stage; pend_o flags tags still ahead of the output stage.
module sweep_tag_pipe
  import trig_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  sweep_tag_t tag_i,
  output sweep_tag_t tag_o,
  output logic       pend_o
);

  sweep_tag_t q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) q[i] <= '0;
    end else begin
      q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) q[i] <= q[i-1];
    end
  end

  assign tag_o = q[LAT-1];

  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pend_o = pend_o | q[i].vld;
  end

endmodule

// File: rtl/angle_sweep_gen.sv
// Angle sweep sequencer feeding the trig lookup stage.
// Optional ANGLE_SWEEP_ALT_EN enables interleaved sin/cos (mode 10).
module angle_sweep_gen
  import trig_pkg::*;
#(
  parameter int TRIG_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DEG_W-1:0] start_deg,
  input  logic [DEG_W-1:0] step,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [1:0]       mode,
  output logic [DEG_W-1:0] degree,
  output logic             iscos,
  output logic             issue,
  input  logic [VAL_W-1:0] trig_value,
  output logic [VAL_W-1:0] samp_value,
  output logic [DEG_W-1:0] samp_degree,
  output logic             samp_iscos,
  output logic             samp_valid,
  output logic             busy,
  output logic             done
);

  sweep_state_e     state_q, state_d;
  logic [DEG_W-1:0] ang_q, ang_d;
  logic [DEG_W-1:0] step_q, step_d;
  logic [DEG_W-1:0] deg_q, deg_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cosm_q, cosm_d;
  logic             cos_q, cos_d;
  logic             iss_q, iss_d;
  logic             busy_q, busy_d;
  logic [VAL_W-1:0] hval_q, hval_d;
  logic [DEG_W-1:0] hdeg_q, hdeg_d;
  logic             hcos_q, hcos_d;
  logic             cosm_c, cos_sel, adv;
  logic             done_c, pend;
  sweep_tag_t       tag_in, tag_out;

`ifdef ANGLE_SWEEP_ALT_EN
  logic alt_q, alt_d, ph_q, ph_d, alt_c;

  always_comb begin
    alt_c  = 1'b0;
    cosm_c = 1'b0;
    unique case (1'b1)
      (mode == MODE_ALT): alt_c  = 1'b1;
      (mode == MODE_COS): cosm_c = 1'b1;
      default: ;
    endcase
    cos_sel = alt_q ? ph_q : cosm_q;
    adv     = !alt_q || ph_q;
  end
`else
  logic unused_mode;

  assign unused_mode = mode[1];
  assign cosm_c      = mode[0];
  assign cos_sel     = cosm_q;
  assign adv         = 1'b1;
`endif

  assign tag_in = '{vld: iss_q, deg: deg_q, cos: cos_q};

  sweep_tag_pipe #(
    .LAT (TRIG_LAT)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_i  (tag_in),
    .tag_o  (tag_out),
    .pend_o (pend)
  );

  // done coincides with the final tag leaving the pipe
  assign done_c = (state_q == S_DRAIN) && !iss_q && !pend;

  always_comb begin
    state_d = state_q;
    ang_d   = ang_q;
    step_d  = step_q;
    deg_d   = deg_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    cosm_d  = cosm_q;
    cos_d   = cos_q;
    iss_d   = 1'b0;
`ifdef ANGLE_SWEEP_ALT_EN
    alt_d   = alt_q;
    ph_d    = ph_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ang_d   = (start_deg >= DEG_FULL_D) ? start_deg - DEG_FULL_D
                                              : start_deg;
          step_d  = (step >= DEG_FULL_D) ? DEG_MAX_D : step;
          n_d     = num_samples;
          cnt_d   = '0;
          cosm_d  = cosm_c;
`ifdef ANGLE_SWEEP_ALT_EN
          alt_d   = alt_c;
          ph_d    = 1'b0;
`endif
          state_d = (num_samples == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DRAIN;
        end else begin
          iss_d = 1'b1;
          deg_d = ang_q;
          cos_d = cos_sel;
          cnt_d = cnt_q + 1'b1;
          if (adv) ang_d = deg_add(ang_q, step_q);
`ifdef ANGLE_SWEEP_ALT_EN
          if (alt_q) ph_d = ~ph_q;
`endif
          if (cnt_q + 1'b1 == n_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (done_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_q != S_IDLE) && !done_c;
  assign hval_d = tag_out.vld ? trig_value  : hval_q;
  assign hdeg_d = tag_out.vld ? tag_out.deg : hdeg_q;
  assign hcos_d = tag_out.vld ? tag_out.cos : hcos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ang_q   <= '0;
      step_q  <= '0;
      deg_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      cosm_q  <= 1'b0;
      cos_q   <= 1'b0;
      iss_q   <= 1'b0;
      busy_q  <= 1'b0;
      hval_q  <= '0;
      hdeg_q  <= '0;
      hcos_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ang_q   <= ang_d;
      step_q  <= step_d;
      deg_q   <= deg_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      cosm_q  <= cosm_d;
      cos_q   <= cos_d;
      iss_q   <= iss_d;
      busy_q  <= busy_d;
      hval_q  <= hval_d;
      hdeg_q  <= hdeg_d;
      hcos_q  <= hcos_d;
    end
  end

`ifdef ANGLE_SWEEP_ALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt_q <= 1'b0;
      ph_q  <= 1'b0;
    end else begin
      alt_q <= alt_d;
      ph_q  <= ph_d;
    end
  end
`endif

  assign degree      = deg_q;
  assign iscos       = cos_q;
  assign issue       = iss_q;
  assign samp_valid  = tag_out.vld;
  assign samp_value  = hval_d;
  assign samp_degree = hdeg_d;
  assign samp_iscos  = hcos_d;
  assign busy        = busy_q;
  assign done        = done_c;

endmodule
